// File: rtl/elastic_alu_output_stage_if.sv
// Elastic join/fork handshake bundle for the PE output stage.
// Operand pair and stop go upstream; per-neighbour data/valid/stop go downstream.
interface elastic_alu_output_stage_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NEIGHBOR_PE_NUM = 4
);
  logic [DATA_WIDTH-1:0]                 input_data_1;
  logic [DATA_WIDTH-1:0]                 input_data_2;
  logic                                  valid_input;
  logic                                  stop_input;
  logic [NEIGHBOR_PE_NUM*DATA_WIDTH-1:0] output_data;
  logic [NEIGHBOR_PE_NUM-1:0]            valid_output;
  logic [NEIGHBOR_PE_NUM-1:0]            stop_output;

  modport master (
    output input_data_1, input_data_2, valid_input, stop_output,
    input  stop_input, output_data, valid_output
  );

  modport slave (
    input  input_data_1, input_data_2, valid_input, stop_output,
    output stop_input, output_data, valid_output
  );
endinterface

// File: rtl/elastic_alu_output_stage.sv
// PE output datapath: combinational elastic ALU -> elastic FIFO -> eager fork.
// Emits per-token context-switch pulses for the ALU and fork contexts.
module elastic_alu_output_stage #(
  parameter int unsigned DATA_WIDTH                     = 32,
  parameter int unsigned ADDRESS_WIDTH                  = 32,
  parameter int unsigned OPERATION_BIT_LENGTH           = 4,
  parameter int unsigned NEIGHBOR_PE_NUM                = 4,
  parameter int unsigned ELASTIC_BUFFER_SIZE            = 2,
  parameter int unsigned ELASTIC_BUFFER_SIZE_BIT_LENGTH = 1
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  elastic_alu_output_stage_if.slave                 bus,
  input  logic [OPERATION_BIT_LENGTH-1:0]           op,
  input  logic [DATA_WIDTH-1:0]                     const_data,
  output logic [ADDRESS_WIDTH-1:0]                  memory_read_address,
  input  logic [DATA_WIDTH-1:0]                     memory_read_data,
  output logic                                      memory_write,
  output logic [ADDRESS_WIDTH-1:0]                  memory_write_address,
  output logic [DATA_WIDTH-1:0]                     memory_write_data,
  input  logic [NEIGHBOR_PE_NUM-1:0]                available_output,
  output logic                                      switch_context_alu,
  output logic                                      switch_context_fork,
  output logic [DATA_WIDTH-1:0]                     alu_output_data,
  output logic [ELASTIC_BUFFER_SIZE_BIT_LENGTH:0]   buffer_data_size
);

  localparam int unsigned PTR_W = ELASTIC_BUFFER_SIZE_BIT_LENGTH;
  localparam int unsigned CNT_W = ELASTIC_BUFFER_SIZE_BIT_LENGTH + 1;

  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_ADD   = OPERATION_BIT_LENGTH'(1);
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_SUB   = OPERATION_BIT_LENGTH'(2);
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_MUL   = OPERATION_BIT_LENGTH'(3);
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_CONST = OPERATION_BIT_LENGTH'(4);
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_LOAD  = OPERATION_BIT_LENGTH'(5);
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_STORE = OPERATION_BIT_LENGTH'(6);
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_ROUTE = OPERATION_BIT_LENGTH'(7);

  logic [DATA_WIDTH-1:0]      operand_a;
  logic [DATA_WIDTH-1:0]      operand_b;
  logic [DATA_WIDTH-1:0]      alu_result;
  logic                       produce;
  logic                       is_store;
  logic                       fire;
  logic                       push;
  logic                       pop;
  logic                       buffer_full;
  logic                       head_valid;
  logic [DATA_WIDTH-1:0]      head_data;

  logic [DATA_WIDTH-1:0]      fifo_mem [ELASTIC_BUFFER_SIZE];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;

  logic [NEIGHBOR_PE_NUM-1:0] done_q;
  logic [NEIGHBOR_PE_NUM-1:0] valid_vec;
  logic [NEIGHBOR_PE_NUM-1:0] taken;
  logic                       complete;

  assign operand_a = bus.input_data_1;
  assign operand_b = bus.input_data_2;

  // Op decode: result value plus whether the op produces a token
  always_comb begin
    alu_result = '0;
    produce    = 1'b0;
    is_store   = 1'b0;
    case (op)
      OP_ADD:   begin alu_result = operand_a + operand_b; produce = 1'b1; end
      OP_SUB:   begin alu_result = operand_a - operand_b; produce = 1'b1; end
      OP_MUL:   begin alu_result = operand_a * operand_b; produce = 1'b1; end
      OP_CONST: begin alu_result = const_data;            produce = 1'b1; end
      OP_LOAD:  begin alu_result = memory_read_data;      produce = 1'b1; end
      OP_ROUTE: begin alu_result = operand_a;             produce = 1'b1; end
      OP_STORE: is_store = 1'b1;
      default:  ;
    endcase
  end

  // Only producing ops see FIFO backpressure; NOP/STORE drain the join freely
  assign buffer_full    = (count == CNT_W'(ELASTIC_BUFFER_SIZE));
  assign head_valid     = (count != '0);
  assign fire           = bus.valid_input & ~(produce & buffer_full);
  assign push           = fire & produce;
  assign bus.stop_input = produce & buffer_full;

  assign switch_context_alu   = fire;
  assign alu_output_data      = alu_result;
  assign memory_read_address  = ADDRESS_WIDTH'(operand_a);
  assign memory_write_address = ADDRESS_WIDTH'(operand_a);
  assign memory_write_data    = operand_b;
  assign memory_write         = fire & is_store;

  // Eager fork: each enabled output takes the head once, pop when all are served
  assign valid_vec        = {NEIGHBOR_PE_NUM{head_valid}} & available_output & ~done_q;
  assign taken            = valid_vec & ~bus.stop_output;
  assign complete         = head_valid & (&(~available_output | done_q | taken));
  assign pop              = complete;
  assign head_data        = fifo_mem[rd_ptr];
  assign bus.valid_output = valid_vec;
  assign bus.output_data  = {NEIGHBOR_PE_NUM{head_data}};

  assign switch_context_fork = complete;
  assign buffer_data_size    = count;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (complete) done_q <= '0;
      else          done_q <= done_q | taken;
    end
  end

endmodule

// File: tb/tb_elastic_alu_output_stage.sv
// Bench for elastic_alu_output_stage: directed scenarios plus a randomized run
// against a queue-based token model.
module tb_elastic_alu_output_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned NP = 4;

  logic        clk;
  logic        reset_n;
  logic [3:0]  op;
  logic [31:0] const_data;
  logic [31:0] memory_read_address;
  logic [31:0] memory_read_data;
  logic        memory_write;
  logic [31:0] memory_write_address;
  logic [31:0] memory_write_data;
  logic [3:0]  available_output;
  logic        switch_context_alu;
  logic        switch_context_fork;
  logic [31:0] alu_output_data;
  logic [1:0]  buffer_data_size;

  int checks;
  int passed;

  elastic_alu_output_stage_if #(.DATA_WIDTH(DW), .NEIGHBOR_PE_NUM(NP)) bus ();

  elastic_alu_output_stage dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .bus                  (bus),
    .op                   (op),
    .const_data           (const_data),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .memory_write         (memory_write),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .available_output     (available_output),
    .switch_context_alu   (switch_context_alu),
    .switch_context_fork  (switch_context_fork),
    .alu_output_data      (alu_output_data),
    .buffer_data_size     (buffer_data_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_alu(input int o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] m);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      1: return a + b;
      2: return a - b;
      3: return p[31:0];
      4: return c;
      5: return m;
      7: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_producing(input int o);
    return (o >= 1 && o <= 5) || o == 7;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_input  = 1'b0;
    bus.input_data_1 = '0;
    bus.input_data_2 = '0;
    op               = 4'd0;
  endtask

  task automatic drive(input int o, input logic [31:0] a, input logic [31:0] b);
    op               = 4'(o);
    bus.input_data_1 = a;
    bus.input_data_2 = b;
    bus.valid_input  = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    next_cycle();
    next_cycle();
    reset_n = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    @(negedge clk);
    checks++; if (buffer_data_size !== 2'd0) $display("FAIL reset_size got=%0d exp=0", buffer_data_size); else passed++;
    checks++; if (bus.valid_output !== 4'b0) $display("FAIL reset_valid got=%b exp=0000", bus.valid_output); else passed++;
    checks++; if (switch_context_fork !== 1'b0) $display("FAIL reset_fork got=%b exp=0", switch_context_fork); else passed++;
    checks++; if (memory_write !== 1'b0) $display("FAIL reset_memwr got=%b exp=0", memory_write); else passed++;
    next_cycle();
  endtask

  task automatic test_add_latency();
    available_output = 4'b0001; bus.stop_output = 4'b0000;
    drive(1, 32'd3, 32'd4);
    @(negedge clk);
    checks++; if (switch_context_alu !== 1'b1) $display("FAIL add_alu_pulse got=%b exp=1", switch_context_alu); else passed++;
    checks++; if (alu_output_data !== 32'd7) $display("FAIL add_result got=%0d exp=7", alu_output_data); else passed++;
    checks++; if (bus.valid_output !== 4'b0) $display("FAIL add_no_comb_path got=%b exp=0000", bus.valid_output); else passed++;
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if (bus.valid_output !== 4'b0001) $display("FAIL add_valid got=%b exp=0001", bus.valid_output); else passed++;
    checks++; if (bus.output_data[31:0] !== 32'd7) $display("FAIL add_out0 got=%0d exp=7", bus.output_data[31:0]); else passed++;
    checks++; if (switch_context_fork !== 1'b1) $display("FAIL add_fork_pulse got=%b exp=1", switch_context_fork); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (buffer_data_size !== 2'd0) $display("FAIL add_drained got=%0d exp=0", buffer_data_size); else passed++;
    next_cycle();
  endtask

  task automatic test_sub_mul();
    available_output = 4'b0001; bus.stop_output = 4'b0000;
    drive(2, 32'd0, 32'd1);
    @(negedge clk);
    checks++; if (alu_output_data !== 32'hFFFF_FFFF) $display("FAIL sub_wrap got=%h exp=ffffffff", alu_output_data); else passed++;
    next_cycle();
    drive(3, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    checks++; if (alu_output_data !== 32'd0) $display("FAIL mul_wrap got=%h exp=0", alu_output_data); else passed++;
    checks++; if (bus.output_data[31:0] !== 32'hFFFF_FFFF) $display("FAIL sub_out got=%h exp=ffffffff", bus.output_data[31:0]); else passed++;
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if (bus.valid_output !== 4'b0001 || bus.output_data[31:0] !== 32'd0)
      $display("FAIL mul_out got=%b/%h exp=0001/0", bus.valid_output, bus.output_data[31:0]); else passed++;
    next_cycle();
  endtask

  task automatic test_load_store();
    available_output = 4'b0001; bus.stop_output = 4'b0000;
    memory_read_data = 32'h55;
    drive(5, 32'h40, 32'd0);
    @(negedge clk);
    checks++; if (memory_read_address !== 32'h40) $display("FAIL load_addr got=%h exp=40", memory_read_address); else passed++;
    checks++; if (alu_output_data !== 32'h55) $display("FAIL load_data got=%h exp=55", alu_output_data); else passed++;
    checks++; if (memory_write !== 1'b0) $display("FAIL load_no_write got=%b exp=0", memory_write); else passed++;
    next_cycle();
    drive(6, 32'd8, 32'd9);
    @(negedge clk);
    checks++; if (bus.output_data[31:0] !== 32'h55 || bus.valid_output !== 4'b0001)
      $display("FAIL load_out got=%b/%h exp=0001/55", bus.valid_output, bus.output_data[31:0]); else passed++;
    checks++; if (memory_write !== 1'b1) $display("FAIL store_strobe got=%b exp=1", memory_write); else passed++;
    checks++; if (memory_write_address !== 32'd8 || memory_write_data !== 32'd9)
      $display("FAIL store_addr_data got=%0d/%0d exp=8/9", memory_write_address, memory_write_data); else passed++;
    checks++; if (switch_context_alu !== 1'b1) $display("FAIL store_alu_pulse got=%b exp=1", switch_context_alu); else passed++;
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if (memory_write !== 1'b0) $display("FAIL store_one_cycle got=%b exp=0", memory_write); else passed++;
    checks++; if (bus.valid_output !== 4'b0 || buffer_data_size !== 2'd0)
      $display("FAIL store_no_token got=%b/%0d exp=0000/0", bus.valid_output, buffer_data_size); else passed++;
    next_cycle();
  endtask

  task automatic test_partial_stop();
    int forks;
    forks = 0;
    available_output = 4'b1111; bus.stop_output = 4'b0100;
    const_data = 32'd42;
    drive(4, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if (alu_output_data !== 32'd42) $display("FAIL const_result got=%0d exp=42", alu_output_data); else passed++;
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if (bus.valid_output !== 4'b1111) $display("FAIL pstop_first got=%b exp=1111", bus.valid_output); else passed++;
    if (switch_context_fork === 1'b1) forks++;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (bus.valid_output !== 4'b0100) $display("FAIL pstop_hold%0d got=%b exp=0100", k, bus.valid_output); else passed++;
      if (switch_context_fork === 1'b1) forks++;
    end
    next_cycle();
    bus.stop_output = 4'b0000;
    @(negedge clk);
    checks++; if (bus.valid_output !== 4'b0100 || bus.output_data[95:64] !== 32'd42)
      $display("FAIL pstop_release got=%b/%0d exp=0100/42", bus.valid_output, bus.output_data[95:64]); else passed++;
    checks++; if (switch_context_fork !== 1'b1) $display("FAIL pstop_fork got=%b exp=1", switch_context_fork); else passed++;
    checks++; if (forks !== 0) $display("FAIL pstop_early_fork got=%0d exp=0", forks); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.valid_output !== 4'b0 || buffer_data_size !== 2'd0)
      $display("FAIL pstop_drained got=%b/%0d exp=0000/0", bus.valid_output, buffer_data_size); else passed++;
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] a [3];
    logic [31:0] b [3];
    for (int k = 0; k < 3; k++) begin a[k] = $urandom; b[k] = $urandom; end
    available_output = 4'b0001; bus.stop_output = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      drive(1, a[k], b[k]);
      @(negedge clk);
      checks++; if (switch_context_alu !== 1'b1 || bus.stop_input !== 1'b0)
        $display("FAIL bp_accept%0d got=%b/%b exp=1/0", k, switch_context_alu, bus.stop_input); else passed++;
      next_cycle();
    end
    drive(1, a[2], b[2]);
    @(negedge clk);
    checks++; if (buffer_data_size !== 2'd2) $display("FAIL bp_full_size got=%0d exp=2", buffer_data_size); else passed++;
    checks++; if (bus.stop_input !== 1'b1 || switch_context_alu !== 1'b0)
      $display("FAIL bp_stall got=%b/%b exp=1/0", bus.stop_input, switch_context_alu); else passed++;
    next_cycle();
    bus.stop_output = 4'b0000;
    @(negedge clk);
    checks++; if (bus.output_data[31:0] !== a[0] + b[0] || switch_context_fork !== 1'b1)
      $display("FAIL bp_tok0 got=%h/%b exp=%h/1", bus.output_data[31:0], switch_context_fork, a[0] + b[0]); else passed++;
    checks++; if (bus.stop_input !== 1'b1) $display("FAIL bp_push_blocked_on_pop got=%b exp=1", bus.stop_input); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.output_data[31:0] !== a[1] + b[1] || switch_context_alu !== 1'b1)
      $display("FAIL bp_tok1 got=%h/%b exp=%h/1", bus.output_data[31:0], switch_context_alu, a[1] + b[1]); else passed++;
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if (bus.output_data[31:0] !== a[2] + b[2] || bus.valid_output !== 4'b0001)
      $display("FAIL bp_tok2 got=%h/%b exp=%h/0001", bus.output_data[31:0], bus.valid_output, a[2] + b[2]); else passed++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    available_output = 4'b0001; bus.stop_output = 4'b1111;
    drive(7, $urandom, 32'd0); next_cycle();
    drive(7, $urandom, 32'd0); next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (buffer_data_size !== 2'd2) $display("FAIL rmid_filled got=%0d exp=2", buffer_data_size); else passed++;
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (buffer_data_size !== 2'd0 || bus.valid_output !== 4'b0)
      $display("FAIL rmid_cleared got=%0d/%b exp=0/0000", buffer_data_size, bus.valid_output); else passed++;
    bus.stop_output = 4'b0000;
    next_cycle();
  endtask

  // Token-level model: queue of pending results plus the set of outputs already served
  task automatic test_random();
    logic [31:0] q[$];
    logic [3:0]  served;
    logic [3:0]  exp_vo, tk;
    bit          full, prod, exp_fire, hv, exp_cmp;
    int          o;
    logic [31:0] a, b;
    q.delete(); served = 4'b0;
    idle_inputs(); bus.stop_output = 4'b0; available_output = 4'b0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      o = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
      b = $urandom;
      drive(o, a, b);
      bus.valid_input  = ($urandom_range(0, 2) != 0);
      const_data       = $urandom;
      memory_read_data = $urandom;
      available_output = 4'($urandom_range(0, 15));
      bus.stop_output  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
      @(negedge clk);
      full     = (q.size() == 2);
      prod     = is_producing(o);
      exp_fire = bus.valid_input && (!prod || !full);
      hv       = (q.size() != 0);
      exp_vo   = hv ? (available_output & ~served) : 4'b0;
      tk       = exp_vo & ~bus.stop_output;
      exp_cmp  = hv && ((~available_output | served | tk) == 4'hF);
      checks++; if (switch_context_alu !== exp_fire) $display("FAIL rnd_alu_pulse c%0d got=%b exp=%b", cyc, switch_context_alu, exp_fire); else passed++;
      checks++; if (bus.stop_input !== (prod && full)) $display("FAIL rnd_stop_in c%0d got=%b exp=%b", cyc, bus.stop_input, prod && full); else passed++;
      checks++; if (memory_write !== (exp_fire && o == 6)) $display("FAIL rnd_memwr c%0d got=%b exp=%b", cyc, memory_write, exp_fire && o == 6); else passed++;
      checks++; if (bus.valid_output !== exp_vo) $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, bus.valid_output, exp_vo); else passed++;
      checks++; if (switch_context_fork !== exp_cmp) $display("FAIL rnd_fork c%0d got=%b exp=%b", cyc, switch_context_fork, exp_cmp); else passed++;
      checks++; if (buffer_data_size !== 2'(q.size())) $display("FAIL rnd_size c%0d got=%0d exp=%0d", cyc, buffer_data_size, q.size()); else passed++;
      if (hv) begin
        checks++; if (bus.output_data !== {4{q[0]}}) $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, bus.output_data, {4{q[0]}}); else passed++;
      end
      if (prod) begin
        checks++; if (alu_output_data !== ref_alu(o, a, b, const_data, memory_read_data))
          $display("FAIL rnd_alu c%0d op=%0d got=%h exp=%h", cyc, o, alu_output_data, ref_alu(o, a, b, const_data, memory_read_data)); else passed++;
      end
      if (exp_cmp) begin void'(q.pop_front()); served = 4'b0; end
      else served = served | tk;
      if (exp_fire && prod) q.push_back(ref_alu(o, a, b, const_data, memory_read_data));
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0; passed = 0;
    reset_n = 1'b1;
    const_data = '0; memory_read_data = '0;
    available_output = 4'b0; bus.stop_output = 4'b0;
    idle_inputs();
    #1;
    test_reset();
    test_add_latency();
    test_sub_mul();
    test_load_store();
    test_partial_stop();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
